// File: rtl/rca_pipe_add_if.sv
// rca_pipe_add_if: operand/result handshake bundle for rca_pipe_add.
// Optional o_overflow member is present only when RCA_PIPE_OVF_EN is defined.
interface rca_pipe_add_if #(
  parameter int WIDTH = 16
);
  // Operand side
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             i_carry_in;
  // Result side
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH:0]   o_result;
`ifdef RCA_PIPE_OVF_EN
  logic             o_overflow;
`endif

  // Producer/consumer view
  modport master (
    output i_valid, i_add_term1, i_add_term2, i_carry_in, i_ready,
    input  o_ready, o_valid, o_result
`ifdef RCA_PIPE_OVF_EN
    , input o_overflow
`endif
  );

  // Adder view
  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_carry_in, i_ready,
    output o_ready, o_valid, o_result
`ifdef RCA_PIPE_OVF_EN
    , output o_overflow
`endif
  );
endinterface

// File: rtl/rca_pipe_add.sv
// rca_pipe_add: WIDTH-bit pipelined ripple-carry adder, one SEG_WIDTH-bit
// segment resolved per stage (NSEG = WIDTH/SEG_WIDTH stages).
// Optional feature macro: RCA_PIPE_OVF_EN adds a registered signed-overflow flag.
//
// Handshake: a beat moves across an interface on a rising edge only when
// valid and ready are both 1 in the cycle before that edge. A producer keeps
// valid and its data stable until it is taken. Each stage loads from the
// stage before it when it is empty or is itself passing its beat on, so
// bubbles collapse and o_ready is a combinational function of i_ready.
module rca_pipe_add #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input logic         i_clk,
  input logic         i_rst_n,
  rca_pipe_add_if.slave bus
);
  localparam int NSEG = WIDTH / SEG_WIDTH;

  if ((WIDTH % SEG_WIDTH) != 0 || WIDTH < SEG_WIDTH) begin : g_bad_cfg
    $error("rca_pipe_add: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  logic [NSEG-1:0] r_vld;      // stage occupancy
  logic [NSEG-1:0] w_src_vld;  // occupancy offered to each stage
  logic [NSEG:0]   w_load;     // w_load[k]: stage k takes a new beat; [NSEG] is the consumer

  // Per-stage ready chain, from the consumer back to the operand port
  always_comb begin
    w_load[NSEG] = bus.i_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      w_load[k] = !r_vld[k] || w_load[k+1];
    end
  end

  // Valid offered to each stage by its upstream neighbour
  always_comb begin
    w_src_vld[0] = bus.i_valid;
    for (int k = 1; k < NSEG; k++) begin
      w_src_vld[k] = r_vld[k-1];
    end
  end

  // Stage occupancy registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (w_load[k]) r_vld[k] <= w_src_vld[k];
      end
    end
  end

  assign bus.o_ready = w_load[0];
  assign bus.o_valid = r_vld[NSEG-1];

  // r_x carries operand A with its already-resolved low segments replaced by
  // sum bits; r_b carries only the still-unused upper bits of operand B.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG_WIDTH;

    logic [WIDTH-1:0]  r_x;
    logic              r_c;
    logic [WIDTH-1:0]  w_src_x;
    logic [WIDTH-1:LO] w_src_b;
    logic              w_src_c;
    logic [WIDTH-1:0]  w_nx;
    logic              w_nc;

    if (k == 0) begin : g_in
      assign w_src_x = bus.i_add_term1;
      assign w_src_b = bus.i_add_term2;
      assign w_src_c = bus.i_carry_in;
    end else begin : g_chain
      assign w_src_x = g_stage[k-1].r_x;
      assign w_src_b = g_stage[k-1].g_mid.r_b;
      assign w_src_c = g_stage[k-1].r_c;
    end

    // Ripple chain of full adders across this stage's segment
    always_comb begin
      logic v_c;
      w_nx = w_src_x;
      v_c  = w_src_c;
      for (int j = 0; j < SEG_WIDTH; j++) begin
        w_nx[LO+j] = w_src_x[LO+j] ^ w_src_b[LO+j] ^ v_c;
        v_c = (w_src_x[LO+j] & w_src_b[LO+j]) | (v_c & (w_src_x[LO+j] | w_src_b[LO+j]));
      end
      w_nc = v_c;
    end

    // Partial sum and segment carry; data only moves with a valid beat
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_x <= '0;
        r_c <= 1'b0;
      end else if (w_load[k] && w_src_vld[k]) begin
        r_x <= w_nx;
        r_c <= w_nc;
      end
    end

    if (k < NSEG - 1) begin : g_mid
      localparam int HI = LO + SEG_WIDTH;
      logic [WIDTH-1:HI] r_b;

      // Forward the unprocessed upper bits of operand B
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_b <= '0;
        end else if (w_load[k] && w_src_vld[k]) begin
          r_b <= w_src_b[WIDTH-1:HI];
        end
      end
    end

`ifdef RCA_PIPE_OVF_EN
    if (k == NSEG - 1) begin : g_ovf
      logic r_ovf;
      logic w_ovf;
      // Carry-in(MSB) xor carry-out(MSB) equals: operand signs agree and
      // the sum sign differs from them. Bit WIDTH-1 of w_src_x is still A.
      assign w_ovf = (w_src_x[WIDTH-1] == w_src_b[WIDTH-1]) &&
                     (w_nx[WIDTH-1] != w_src_x[WIDTH-1]);

      // Overflow flag travels with the output-stage result
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_load[k] && w_src_vld[k]) begin
          r_ovf <= w_ovf;
        end
      end
    end
`endif
  end

  assign bus.o_result = {g_stage[NSEG-1].r_c, g_stage[NSEG-1].r_x};
`ifdef RCA_PIPE_OVF_EN
  assign bus.o_overflow = g_stage[NSEG-1].g_ovf.r_ovf;
`endif
endmodule

// File: tb/tb_rca_pipe_add.sv
// tb_rca_pipe_add: directed + random bench for rca_pipe_add (WIDTH=16, SEG_WIDTH=4).
// Define RCA_PIPE_OVF_EN to also cover the overflow flag.
module tb_rca_pipe_add;
  localparam int W    = 16;
  localparam int S    = 4;
  localparam int NSEG = W / S;

  logic clk;
  logic rst_n;

  rca_pipe_add_if #(.WIDTH(W)) bus ();

  rca_pipe_add #(.WIDTH(W), .SEG_WIDTH(S)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int accepted = 0;
  int retired  = 0;
  logic [W:0] exp_q[$];
`ifdef RCA_PIPE_OVF_EN
  logic       exp_ovf_q[$];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    longint unsigned s;
    s = longint'(a) + longint'(b) + longint'(c);
    return s[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = sa + sb + longint'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // ---------------- monitor: retire, accept, producer rule ----------------
  logic           pend;
  logic [W-1:0]   p_a, p_b;
  logic           p_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (bus.o_valid && bus.i_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_result observed=%0h expected=none", bus.o_result);
        end
        if (exp_q.size() > 0) begin
          chk("result", 32'(bus.o_result), 32'(exp_q.pop_front()));
`ifdef RCA_PIPE_OVF_EN
          chk("overflow", 32'(bus.o_overflow), 32'(exp_ovf_q.pop_front()));
`endif
        end
        retired++;
      end
      if (pend) begin
        chk("producer_hold", {bus.i_valid, bus.i_carry_in, bus.i_add_term2[6:0], bus.i_add_term1},
            {1'b1, p_c, p_b[6:0], p_a});
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(ref_sum(bus.i_add_term1, bus.i_add_term2, bus.i_carry_in));
`ifdef RCA_PIPE_OVF_EN
        exp_ovf_q.push_back(ref_ovf(bus.i_add_term1, bus.i_add_term2, bus.i_carry_in));
`endif
        accepted++;
      end
      pend = bus.i_valid && !bus.o_ready;
      p_a  = bus.i_add_term1;
      p_b  = bus.i_add_term2;
      p_c  = bus.i_carry_in;
    end
  end

  // ---------------- driver tasks ----------------
  // Present one beat at posedge+1 and hold it until taken; returns at posedge+1
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int waited);
    waited = 0;
    bus.i_valid     = 1'b1;
    bus.i_add_term1 = a;
    bus.i_add_term2 = b;
    bus.i_carry_in  = c;
    @(negedge clk);
    while (!bus.o_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk("drive_timeout", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic expect_next(input string tag, input logic [W:0] er, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
    chk(tag, 32'(bus.o_result), 32'(er));
`ifdef RCA_PIPE_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.o_overflow), 32'(eo));
`else
    if (eo === 1'bx) $display("note: undefined overflow expectation for %s", tag);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk({tag, "_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_count"}, 32'(retired), 32'(accepted));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int             w;
    int             n_acc;
    logic           have_frz;
    logic [W:0]     frz;
    logic [W-1:0]   ca, cb;
    logic           cc;

    rst_n           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_add_term1 = '0;
    bus.i_add_term2 = '0;
    bus.i_carry_in  = 1'b0;
    bus.i_ready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_result", 32'(bus.o_result), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single beat: exact latency and value, then o_valid drops
    drive(16'h1234, 16'h4321, 1'b0, w);
    for (int i = 0; i < NSEG - 1; i++) begin
      @(negedge clk);
      chk("lat_early_valid", 32'(bus.o_valid), 32'd0);
    end
    @(negedge clk);
    chk("lat_valid", 32'(bus.o_valid), 32'd1);
    chk("lat_result", 32'(bus.o_result), 32'h05555);
    @(negedge clk);
    chk("lat_after_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;

    // Full carry ripple and signed-overflow corner cases
    drive(16'hFFFF, 16'h0000, 1'b1, w);
    drive(16'hFFFF, 16'hFFFF, 1'b1, w);
    expect_next("ripple_a", 17'h10000, 1'b0);
    expect_next("ripple_b", 17'h1FFFF, 1'b0);
    drive(16'h7FFF, 16'h0001, 1'b0, w);
    drive(16'h8000, 16'hFFFF, 1'b0, w);
    drive(16'h0001, 16'h0001, 1'b0, w);
    expect_next("ovf_pos", 17'h08000, 1'b1);
    expect_next("ovf_neg", 17'h17FFF, 1'b1);
    expect_next("ovf_none", 17'h00002, 1'b0);
    wait_drain("directed");

    // 100 back-to-back random beats, o_ready must never drop
    for (int i = 0; i < 100; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), w);
      chk("stream_ready_wait", 32'(w), 32'd0);
    end
    wait_drain("stream");

    // Stall: consumer blocked for 10 cycles while producer keeps offering
    bus.i_ready     = 1'b0;
    n_acc           = 0;
    have_frz        = 1'b0;
    frz             = '0;
    ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom_range(0, 1));
    bus.i_valid     = 1'b1;
    bus.i_add_term1 = ca;
    bus.i_add_term2 = cb;
    bus.i_carry_in  = cc;
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic acc;
      @(negedge clk);
      chk("stall_ready", 32'(bus.o_ready), 32'(n_acc < NSEG));
      if (bus.o_valid) begin
        if (have_frz) chk("stall_frozen", 32'(bus.o_result), 32'(frz));
        else begin
          frz      = bus.o_result;
          have_frz = 1'b1;
        end
      end
      acc = bus.o_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom_range(0, 1));
        bus.i_add_term1 = ca;
        bus.i_add_term2 = cb;
        bus.i_carry_in  = cc;
      end
    end
    chk("stall_fill_count", 32'(n_acc), 32'(NSEG));
    bus.i_ready = 1'b1;
    drive(ca, cb, cc, w);
    for (int i = 0; i < 5; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), w);
    end
    wait_drain("stall");

    // Asynchronous reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), w);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_o_result", 32'(bus.o_result), 32'd0);
    exp_q.delete();
`ifdef RCA_PIPE_OVF_EN
    exp_ovf_q.delete();
`endif
    accepted = 0;
    retired  = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ca = W'($urandom); cb = W'($urandom); cc = 1'($urandom_range(0, 1));
    drive(ca, cb, cc, w);
    expect_next("post_reset_first", ref_sum(ca, cb, cc), ref_ovf(ca, cb, cc));
    wait_drain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
